mips_instr_encoder: RTL and testbench

MIPS_INSTR_ENCODER -- requirements
Module: mips_instr_encoder

---
 rtl/mips_instr_encoder.sv | 206 ++++++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : mips_instr_encoder
//  Purpose  : Assembles MIPS instructions from separate fields and writes the
//             32-bit words into an instruction memory, one load session at a
//             time. Illegal class codes are counted and skipped.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             start, base_addr    - open a session at base_addr (IDLE only)
//             in_valid/in_ready   - field handshake, in_last ends the session
//             op_sel..target      - instruction class code and raw fields
//             mem_we/addr/wdata   - instruction-memory write port
//             done                - one-cycle end-of-session pulse
//             err_illegal/count   - sticky flag and saturating reject count
//             wrapped             - sticky flag: a write hit the top address
//  Revision : 1.0  initial release
// ============================================================================
module mips_instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err_illegal,
    output logic [7:0]        err_count,
    output logic              wrapped
);

    localparam logic [1:0] c_STATE_IDLE  = 2'd0;
    localparam logic [1:0] c_STATE_LOAD  = 2'd1;
    localparam logic [1:0] c_STATE_WRITE = 2'd2;
    localparam logic [1:0] c_STATE_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_last;
    logic              r_inReady;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [31:0]       r_memWdata;
    logic              r_done;
    logic              r_errIllegal;
    logic [7:0]        r_errCount;
    logic              r_wrapped;

    logic [5:0]  w_opcode;
    logic        w_legal;
    logic        w_isR;
    logic        w_isJ;
    logic        w_isJr;
    logic        w_isShift;
    logic        w_isLui;
    logic [4:0]  w_rsF;
    logic [4:0]  w_rtF;
    logic [4:0]  w_rdF;
    logic [4:0]  w_shamtF;
    logic [31:0] w_word;

    // Class code to primary opcode
    always_comb begin
        w_opcode = 6'b000000;
        w_legal  = 1'b1;
        case (op_sel)
            5'd0:    w_opcode = 6'b000000;
            5'd1:    w_opcode = 6'b001000;
            5'd2:    w_opcode = 6'b001001;
            5'd3:    w_opcode = 6'b001100;
            5'd4:    w_opcode = 6'b000100;
            5'd5:    w_opcode = 6'b000101;
            5'd6:    w_opcode = 6'b000010;
            5'd7:    w_opcode = 6'b000011;
            5'd8:    w_opcode = 6'b100100;
            5'd9:    w_opcode = 6'b100101;
            5'd10:   w_opcode = 6'b001111;
            5'd11:   w_opcode = 6'b100011;
            5'd12:   w_opcode = 6'b001101;
            5'd13:   w_opcode = 6'b001010;
            5'd14:   w_opcode = 6'b001011;
            5'd15:   w_opcode = 6'b101000;
            5'd16:   w_opcode = 6'b101001;
            5'd17:   w_opcode = 6'b101011;
            default: w_legal  = 1'b0;
        endcase
    end

    // Field canonicalisation: jr carries only rs, sll/srl carry no rs, and
    // lui has no source register. Unused fields are forced to zero so the
    // written word does not depend on whatever the producer left there.
    assign w_isR     = (op_sel == 5'd0);
    assign w_isJ     = (op_sel == 5'd6) || (op_sel == 5'd7);
    assign w_isJr    = w_isR && (funct == 6'b001000);
    assign w_isShift = w_isR && ((funct == 6'b000000) || (funct == 6'b000010));
    assign w_isLui   = (op_sel == 5'd10);

    assign w_rsF    = (w_isShift || w_isLui) ? 5'd0 : rs;
    assign w_rtF    = w_isJr ? 5'd0 : rt;
    assign w_rdF    = w_isJr ? 5'd0 : rd;
    assign w_shamtF = w_isJr ? 5'd0 : shamt;

    assign w_word = w_isR ? {6'b000000, w_rsF, w_rtF, w_rdF, w_shamtF, funct} :
                    w_isJ ? {w_opcode, target} :
                            {w_opcode, w_rsF, rt, imm};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_STATE_IDLE;
            r_addr       <= '0;
            r_last       <= 1'b0;
            r_inReady    <= 1'b0;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= 32'd0;
            r_done       <= 1'b0;
            r_errIllegal <= 1'b0;
            r_errCount   <= 8'd0;
            r_wrapped    <= 1'b0;
        end else begin
            r_memWe <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                c_STATE_IDLE: begin
                    if (start) begin
                        r_state      <= c_STATE_LOAD;
                        r_addr       <= base_addr;
                        r_inReady    <= 1'b1;
                        r_errIllegal <= 1'b0;
                        r_errCount   <= 8'd0;
                        r_wrapped    <= 1'b0;
                    end
                end
                c_STATE_LOAD: begin
                    if (in_valid && r_inReady) begin
                        if (w_legal) begin
                            // Write-port registers are loaded at accept so the
                            // write is presented throughout the WRITE cycle.
                            r_state    <= c_STATE_WRITE;
                            r_inReady  <= 1'b0;
                            r_last     <= in_last;
                            r_memWe    <= 1'b1;
                            r_memAddr  <= r_addr;
                            r_memWdata <= w_word;
                            r_addr     <= r_addr + c_ADDR_ONE;
                        end else begin
                            r_errIllegal <= 1'b1;
                            if (r_errCount != 8'hFF) begin
                                r_errCount <= r_errCount + 8'd1;
                            end
                            if (in_last) begin
                                r_state   <= c_STATE_DONE;
                                r_inReady <= 1'b0;
                                r_done    <= 1'b1;
                            end
                        end
                    end
                end
                c_STATE_WRITE: begin
                    if (&r_memAddr) begin
                        r_wrapped <= 1'b1;
                    end
                    if (r_last) begin
                        r_state <= c_STATE_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= c_STATE_LOAD;
                        r_inReady <= 1'b1;
                    end
                end
                c_STATE_DONE: begin
                    r_state <= c_STATE_IDLE;
                end
                default: begin
                    r_state   <= c_STATE_IDLE;
                    r_inReady <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_inReady;
    assign mem_we      = r_memWe;
    assign mem_addr    = r_memAddr;
    assign mem_wdata   = r_memWdata;
    assign done        = r_done;
    assign err_illegal = r_errIllegal;
    assign err_count   = r_errCount;
    assign wrapped     = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_instr_encoder
//  Purpose  : Self-checking bench for mips_instr_encoder. Directed scenarios
//             plus randomized sessions checked against a field-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [4:0]  op_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err_illegal;
    logic [7:0]  err_count;
    logic        wrapped;

    int nChecks = 0;
    int nFails  = 0;

    // Primary opcodes indexed by class code (decimal values of the 6-bit field)
    int opTab [0:17] = '{0, 8, 9, 12, 4, 5, 2, 3, 36, 37, 15, 35, 13, 10, 11, 40, 41, 43};

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .err_illegal(err_illegal), .err_count(err_count),
        .wrapped(wrapped)
    );

    // Reference encoder: builds the word by weighting each field by its bit
    // position, after applying the field-zeroing rules.
    function automatic logic [31:0] refEncode(input int op, input int s0, input int t0,
                                              input int d0, input int h0, input int fn,
                                              input int im, input int tg);
        longint w;
        int s = s0;
        int t = t0;
        int d = d0;
        int h = h0;
        if (op == 0) begin
            if (fn == 8) begin
                t = 0; d = 0; h = 0;
            end
            if (fn == 0 || fn == 2) s = 0;
            w = longint'(s) * 2097152 + longint'(t) * 65536 + longint'(d) * 2048
                + longint'(h) * 64 + longint'(fn);
        end else if (op == 6 || op == 7) begin
            w = longint'(opTab[op]) * 67108864 + longint'(tg);
        end else begin
            if (op == 10) s = 0;
            w = longint'(opTab[op]) * 67108864 + longint'(s) * 2097152
                + longint'(t) * 65536 + longint'(im);
        end
        return w[31:0];
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
    endtask

    task automatic startSession(input logic [7:0] base);
        start     = 1'b1;
        base_addr = base;
        stepCycle();
        start     = 1'b0;
        base_addr = 8'h00;
    endtask

    // Presents one entry and holds it until accepted; returns #1 after the
    // accepting edge. ok=0 when in_ready never came within the budget.
    task automatic sendEntry(input logic [4:0] op, input logic [4:0] s, input logic [4:0] t,
                             input logic [4:0] d, input logic [4:0] h, input logic [5:0] fn,
                             input logic [15:0] im, input logic [25:0] tg, input logic last,
                             output bit ok);
        op_sel = op; rs = s; rt = t; rd = d; shamt = h; funct = fn;
        imm = im; target = tg; in_last = last; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            stepCycle();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stepCycle();
        stepCycle();
        reset = 1'b0;
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        nChecks++; if (mem_we !== 1'b0) begin nFails++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL reset_done: got %b want 0", done); end
        nChecks++; if (err_illegal !== 1'b0) begin nFails++; $display("FAIL reset_err_illegal: got %b want 0", err_illegal); end
        nChecks++; if (err_count !== 8'd0) begin nFails++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        nChecks++; if (wrapped !== 1'b0) begin nFails++; $display("FAIL reset_wrapped: got %b want 0", wrapped); end
        nChecks++; if (mem_addr !== 8'd0) begin nFails++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        nChecks++; if (mem_wdata !== 32'd0) begin nFails++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        // start during reset must be overridden
        start = 1'b1;
        applyReset();
        start = 1'b0;
        nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL reset_overrides_start: in_ready got %b want 0", in_ready); end
    endtask

    task automatic test_addi();
        bit ok;
        startSession(8'h10);
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL addi_ready: got %b want 1", in_ready); end
        sendEntry(5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b1, ok);
        nChecks++; if (ok !== 1'b1) begin nFails++; $display("FAIL addi_accept: got %b want 1", ok); end
        nChecks++; if (mem_we !== 1'b1) begin nFails++; $display("FAIL addi_we: got %b want 1", mem_we); end
        nChecks++; if (mem_addr !== 8'h10) begin nFails++; $display("FAIL addi_addr: got %h want 10", mem_addr); end
        nChecks++; if (mem_wdata !== 32'h20430005) begin nFails++; $display("FAIL addi_wdata: got %h want 20430005", mem_wdata); end
        nChecks++; if (in_ready !== 1'b0 || done !== 1'b0) begin nFails++; $display("FAIL addi_write_cycle: ready %b done %b want 0 0", in_ready, done); end
        stepCycle();
        nChecks++; if (done !== 1'b1) begin nFails++; $display("FAIL addi_done: got %b want 1", done); end
        nChecks++; if (mem_we !== 1'b0 || mem_addr !== 8'h10 || mem_wdata !== 32'h20430005) begin
            nFails++; $display("FAIL addi_hold: we %b addr %h data %h want 0 10 20430005", mem_we, mem_addr, mem_wdata); end
        stepCycle();
        nChecks++; if (done !== 1'b0 || in_ready !== 1'b0) begin nFails++; $display("FAIL addi_idle: done %b ready %b want 0 0", done, in_ready); end
        nChecks++; if (wrapped !== 1'b0) begin nFails++; $display("FAIL addi_wrapped: got %b want 0", wrapped); end
    endtask

    task automatic test_rtype_j();
        bit ok;
        startSession(8'h40);
        sendEntry(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'hFFFF, 26'h3FFFFFF, 1'b0, ok);
        nChecks++; if (ok !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h40 || mem_wdata !== 32'h00221820) begin
            nFails++; $display("FAIL rtype_write: ok %b we %b addr %h data %h want 1 1 40 00221820", ok, mem_we, mem_addr, mem_wdata); end
        stepCycle();
        nChecks++; if (in_ready !== 1'b1 || done !== 1'b0) begin nFails++; $display("FAIL rtype_back_to_load: ready %b done %b want 1 0", in_ready, done); end
        // start outside IDLE must be ignored
        start = 1'b1; base_addr = 8'hAA;
        stepCycle();
        start = 1'b0;
        sendEntry(5'd6, 5'd9, 5'd9, 5'd9, 5'd9, 6'd9, 16'h1234, 26'h0000040, 1'b1, ok);
        nChecks++; if (ok !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h41 || mem_wdata !== 32'h08000040) begin
            nFails++; $display("FAIL j_write: ok %b we %b addr %h data %h want 1 1 41 08000040", ok, mem_we, mem_addr, mem_wdata); end
        stepCycle();
        nChecks++; if (done !== 1'b1) begin nFails++; $display("FAIL j_done: got %b want 1", done); end
        stepCycle();
    endtask

    task automatic test_jr();
        bit ok;
        startSession(8'h50);
        sendEntry(5'd0, 5'd31, 5'd5, 5'd7, 5'd3, 6'b001000, 16'd0, 26'd0, 1'b0, ok);
        nChecks++; if (ok !== 1'b1 || mem_wdata !== 32'h03E00008) begin
            nFails++; $display("FAIL jr_wdata: ok %b got %h want 03E00008", ok, mem_wdata); end
        // sll with a non-zero rs: rs must be dropped
        sendEntry(5'd0, 5'd12, 5'd4, 5'd5, 5'd2, 6'b000000, 16'd0, 26'd0, 1'b0, ok);
        nChecks++; if (ok !== 1'b1 || mem_wdata !== 32'h00042880) begin
            nFails++; $display("FAIL sll_wdata: ok %b got %h want 00042880", ok, mem_wdata); end
        // lui with a non-zero rs: rs must be dropped
        sendEntry(5'd10, 5'd7, 5'd8, 5'd0, 5'd0, 6'd0, 16'hBEEF, 26'd0, 1'b1, ok);
        nChecks++; if (ok !== 1'b1 || mem_wdata !== 32'h3C08BEEF || mem_addr !== 8'h52) begin
            nFails++; $display("FAIL lui_wdata: ok %b got %h @%h want 3C08BEEF @52", ok, mem_wdata, mem_addr); end
        stepCycle();
        stepCycle();
    endtask

    task automatic test_illegal();
        bit ok;
        startSession(8'h30);
        sendEntry(5'd20, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b0, ok);
        nChecks++; if (ok !== 1'b1 || mem_we !== 1'b0) begin nFails++; $display("FAIL illegal_no_write: ok %b we %b want 1 0", ok, mem_we); end
        nChecks++; if (err_illegal !== 1'b1 || err_count !== 8'd1) begin
            nFails++; $display("FAIL illegal_err: flag %b count %0d want 1 1", err_illegal, err_count); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL illegal_stay_load: ready %b want 1", in_ready); end
        sendEntry(5'd17, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b1, ok);
        nChecks++; if (ok !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h30 || mem_wdata !== 32'hAC850010) begin
            nFails++; $display("FAIL sw_write: ok %b we %b addr %h data %h want 1 1 30 AC850010", ok, mem_we, mem_addr, mem_wdata); end
        stepCycle();
        stepCycle();
        startSession(8'h00);
        nChecks++; if (err_illegal !== 1'b0 || err_count !== 8'd0) begin
            nFails++; $display("FAIL start_clears_err: flag %b count %0d want 0 0", err_illegal, err_count); end
    endtask

    task automatic test_saturate();
        bit ok;
        // continues the session opened by test_illegal
        for (int i = 0; i < 258; i++) begin
            sendEntry(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0, ok);
        end
        nChecks++; if (err_count !== 8'd255) begin nFails++; $display("FAIL err_saturate: got %0d want 255", err_count); end
        sendEntry(5'd18, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1, ok);
        nChecks++; if (done !== 1'b1 || mem_we !== 1'b0 || err_count !== 8'd255) begin
            nFails++; $display("FAIL illegal_last_done: done %b we %b count %0d want 1 0 255", done, mem_we, err_count); end
        stepCycle();
    endtask

    task automatic test_wrap();
        bit ok;
        startSession(8'hFF);
        sendEntry(5'd11, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0, ok);
        nChecks++; if (ok !== 1'b1 || mem_addr !== 8'hFF || mem_we !== 1'b1) begin
            nFails++; $display("FAIL wrap_first: ok %b addr %h we %b want 1 FF 1", ok, mem_addr, mem_we); end
        sendEntry(5'd12, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00F0, 26'd0, 1'b1, ok);
        nChecks++; if (ok !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 32'h346400F0) begin
            nFails++; $display("FAIL wrap_second: ok %b addr %h data %h want 1 00 346400F0", ok, mem_addr, mem_wdata); end
        stepCycle();
        nChecks++; if (wrapped !== 1'b1 || done !== 1'b1) begin nFails++; $display("FAIL wrap_flag: wrapped %b done %b want 1 1", wrapped, done); end
        stepCycle();
    endtask

    task automatic test_reset_in_write();
        bit ok;
        startSession(8'h20);
        sendEntry(5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b0, ok);
        nChecks++; if (ok !== 1'b1 || mem_we !== 1'b1) begin nFails++; $display("FAIL rstw_pre: ok %b we %b want 1 1", ok, mem_we); end
        applyReset();
        nChecks++; if (mem_we !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            nFails++; $display("FAIL rstw_ctrl: we %b ready %b done %b want 0 0 0", mem_we, in_ready, done); end
        nChecks++; if (mem_addr !== 8'd0 || mem_wdata !== 32'd0 || err_count !== 8'd0 || err_illegal !== 1'b0 || wrapped !== 1'b0) begin
            nFails++; $display("FAIL rstw_data: addr %h data %h cnt %0d err %b wrap %b want all 0", mem_addr, mem_wdata, err_count, err_illegal, wrapped); end
        stepCycle();
        nChecks++; if (mem_we !== 1'b0 || in_ready !== 1'b0) begin nFails++; $display("FAIL rstw_idle: we %b ready %b want 0 0", mem_we, in_ready); end
    endtask

    task automatic test_random();
        bit ok;
        for (int sess = 0; sess < 12; sess++) begin
            int base = $urandom_range(0, 255);
            int nEnt = $urandom_range(1, 8);
            int expAddr = base;
            int expErr = 0;
            bit expWrap = 0;
            bit lastLegal = 0;
            startSession(base[7:0]);
            for (int e = 0; e < nEnt; e++) begin
                int op = $urandom_range(0, 22);
                int s  = $urandom_range(0, 31);
                int t  = $urandom_range(0, 31);
                int d  = $urandom_range(0, 31);
                int h  = $urandom_range(0, 31);
                int fn = ($urandom_range(0, 3) == 0) ? 8 : (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 63));
                int im = $urandom_range(0, 65535);
                int tg = $urandom_range(0, 67108863);
                bit last = (e == nEnt - 1);
                repeat ($urandom_range(0, 2)) stepCycle();
                sendEntry(op[4:0], s[4:0], t[4:0], d[4:0], h[4:0], fn[5:0], im[15:0], tg[25:0], last, ok);
                if (op <= 17) begin
                    logic [31:0] expW = refEncode(op, s, t, d, h, fn, im, tg);
                    nChecks++; if (ok !== 1'b1 || mem_we !== 1'b1 || mem_addr !== expAddr[7:0] || mem_wdata !== expW) begin
                        nFails++; $display("FAIL rand_write op %0d: ok %b we %b addr %h data %h want 1 1 %h %h",
                                           op, ok, mem_we, mem_addr, mem_wdata, expAddr[7:0], expW); end
                    if (expAddr == 255) expWrap = 1;
                    expAddr = (expAddr + 1) % 256;
                    lastLegal = 1;
                end else begin
                    expErr++;
                    nChecks++; if (ok !== 1'b1 || mem_we !== 1'b0 || err_count !== expErr[7:0] || err_illegal !== 1'b1) begin
                        nFails++; $display("FAIL rand_illegal op %0d: ok %b we %b cnt %0d err %b want 1 0 %0d 1",
                                           op, ok, mem_we, err_count, err_illegal, expErr); end
                    lastLegal = 0;
                end
            end
            if (lastLegal) stepCycle();
            nChecks++; if (done !== 1'b1) begin nFails++; $display("FAIL rand_done sess %0d: got %b want 1", sess, done); end
            stepCycle();
            nChecks++; if (wrapped !== expWrap || err_illegal !== (expErr != 0) || done !== 1'b0) begin
                nFails++; $display("FAIL rand_flags sess %0d: wrap %b err %b done %b want %b %b 0",
                                   sess, wrapped, err_illegal, done, expWrap, (expErr != 0)); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        op_sel = 5'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; funct = 6'd0;
        imm = 16'd0; target = 26'd0;
        test_reset();
        test_addi();
        test_rtype_j();
        test_jr();
        test_illegal();
        test_saturate();
        test_wrap();
        test_reset_in_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
